pll_reset_seq: RTL and testbench
================================

# pll_reset_seq

Reset sequencer at the consuming end of the Artix-7 PLL clock generator. It drives the PLL's RST input, watches the PLL's asynchronous LOCKED output, and releases the system reset only after lock has been held stable. On any loss of lock it re-asserts system reset and restarts the PLL. It runs on a free-running clock that does not come from the PLL (e.g. the buffered board reference) and feeds the reset tree of the top level.

## Interface
Parameters:
- PLL_RST_CYCLES, 16: cycles pll_rst_o is held high per PLL reset attempt; range 1..2^24-1
- LOCK_TIMEOUT, 65536: cycles to wait for lock before retrying the PLL reset; range 1..2^24-1
- STABLE_CYCLES, 1024: cycles lock must stay continuously high before system reset is released; range 1..2^24-1

Ports:
- clk_i, input, 1: free-running reference clock, not PLL-derived
- rst_n_i, input, 1: reset, synchronous, active-low
- pll_locked_i, input, 1: PLL LOCKED, asynchronous to clk_i
- pll_rst_o, output, 1: PLL RST, active high
- rst_o, output, 1: system reset, active high
- ready_o, output, 1: high while the sequencer is in RUN
- lock_lost_o, output, 1: one-cycle pulse when lock drops while in RUN
- timeout_count_o, output, 8: saturating count of lock timeouts
- lockloss_count_o, output, 8: saturating count of lock losses in RUN

## Operation
- pll_locked_i passes through a 2-flop synchronizer. Both flops reset to 0. The FSM uses only the second flop, locked_s.
- One 24-bit counter, cnt. It is cleared on every state transition.
- All outputs are registered and decoded from the next state, so each output changes on the same edge as the state.
- State RESET_PLL:
  - pll_rst_o=1, rst_o=1, ready_o=0.
  - When cnt==PLL_RST_CYCLES-1, go to WAIT_LOCK. Otherwise cnt++.
- State WAIT_LOCK:
  - pll_rst_o=0, rst_o=1.
  - If locked_s=1, go to STABLE.
  - Else if cnt==LOCK_TIMEOUT-1, go to RESET_PLL and increment timeout_count_o (saturates at 255).
  - Else cnt++.
- State STABLE:
  - pll_rst_o=0, rst_o=1.
  - If locked_s=0, go to WAIT_LOCK. The timeout restarts from 0 and no counter increments.
  - Else if cnt==STABLE_CYCLES-1, go to RUN.
  - Else cnt++.
- State RUN:
  - pll_rst_o=0, rst_o=0, ready_o=1.
  - If locked_s=0, go to RESET_PLL, pulse lock_lost_o for exactly one cycle, and increment lockloss_count_o (saturates at 255).
- Retries are unlimited. The sequencer never enters a terminal error state.

## Timing
- Reset is sampled at the clk_i edge where rst_n_i=0. After that edge:
  - state=RESET_PLL, cnt=0, synchronizer=0
  - pll_rst_o=1, rst_o=1, ready_o=0, lock_lost_o=0
  - timeout_count_o=0, lockloss_count_o=0
- Reset asserted mid-operation (any state) restores exactly the values above on the next edge, including clearing both counters.
- After reset release, pll_rst_o stays high for exactly PLL_RST_CYCLES cycles, then falls.
- Lock acquire latency: pll_locked_i rises before edge E0 (state WAIT_LOCK). Then:
  - locked_s=1 after E1
  - STABLE is entered at E2
  - RUN is entered, rst_o falls and ready_o rises at edge E2+STABLE_CYCLES
- Lock loss latency: pll_locked_i falls before edge E0 while in RUN. At E2, rst_o=1, pll_rst_o=1, ready_o=0 and lock_lost_o=1. At E3, lock_lost_o=0.
- Glitch filtering: a lock dropout of at least one sampled cycle during STABLE restarts qualification. A dropout shorter than one clk_i period may be missed; this is acceptable.
- A PLL that never locks cycles with period PLL_RST_CYCLES+LOCK_TIMEOUT. timeout_count_o increments once per period.
- Simultaneous events:
  - WAIT_LOCK with locked_s=1 on the timeout cycle: lock wins, go to STABLE, no timeout counted.
  - STABLE with locked_s=0 on the final cycle: the drop wins, go to WAIT_LOCK.
- STABLE_CYCLES=1 and PLL_RST_CYCLES=1 are legal. Each state then lasts one cycle.

## Test plan
Bench parameters: PLL_RST_CYCLES=4, LOCK_TIMEOUT=32, STABLE_CYCLES=8.
- Reset then lock: hold rst_n_i=0 for 3 cycles, release, then raise pll_locked_i 10 cycles later.
  - pll_rst_o high exactly 4 cycles.
  - rst_o falls exactly 10 edges after the lock rise.
  - ready_o=1, both counters 0.
- No lock: keep pll_locked_i=0 for 200 cycles.
  - pll_rst_o pulses 4 cycles high every 36 cycles.
  - timeout_count_o=5 after cycle 180.
  - rst_o stays 1.
- Unstable lock: in STABLE, drop pll_locked_i for 1 cycle at stable cycle 5, then hold high.
  - FSM returns to WAIT_LOCK and requalifies.
  - rst_o falls 8 cycles after re-entering STABLE, i.e. 10 edges after the re-rise.
  - timeout_count_o unchanged.
- Lock loss in RUN: drop pll_locked_i.
  - 2 edges later: rst_o=1, pll_rst_o=1, and lock_lost_o=1 for one cycle.
  - lockloss_count_o=1.
  - Relock gives a full sequence again.
- Saturation: force 300 timeouts.
  - timeout_count_o holds at 255 and does not wrap.
- Reset mid-STABLE: assert rst_n_i at STABLE cycle 3.
  - All outputs return to reset values on the next edge.
  - The sequence restarts with a 4-cycle pll_rst_o.

Source files
------------

// File: rtl/pll_reset_seq.sv
// PLL reset sequencer: pulses the PLL reset, qualifies LOCKED for a stable
// window, then releases the system reset; any lock loss restarts the sequence.
//
// state       | meaning
// ------------+-------------------------------------------------------------
// S_RESET_PLL | PLL RST held high for PLL_RST_CYCLES
// S_WAIT_LOCK | PLL running, waiting up to LOCK_TIMEOUT cycles for lock
// S_STABLE    | lock seen, must stay high STABLE_CYCLES before release
// S_RUN       | system reset released, watching for lock loss
module pll_reset_seq #(
    parameter int unsigned PLL_RST_CYCLES = 16,
    parameter int unsigned LOCK_TIMEOUT   = 65536,
    parameter int unsigned STABLE_CYCLES  = 1024
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       pll_locked_i,
    output logic       pll_rst_o,
    output logic       rst_o,
    output logic       ready_o,
    output logic       lock_lost_o,
    output logic [7:0] timeout_count_o,
    output logic [7:0] lockloss_count_o
);

    localparam logic [23:0] RST_LAST     = 24'(PLL_RST_CYCLES - 1);
    localparam logic [23:0] TIMEOUT_LAST = 24'(LOCK_TIMEOUT - 1);
    localparam logic [23:0] STABLE_LAST  = 24'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_RESET_PLL,
        S_WAIT_LOCK,
        S_STABLE,
        S_RUN
    } state_t;

    state_t      state;
    state_t      state_n;
    logic [23:0] cnt;
    logic        sync1;
    logic        locked_s;
    logic        timeout_evt;
    logic        lockloss_evt;

    always_comb begin
        state_n      = state;
        timeout_evt  = 1'b0;
        lockloss_evt = 1'b0;
        case (state)
            S_RESET_PLL: begin
                if (cnt == RST_LAST) state_n = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                // Lock takes priority over a coincident timeout.
                if (locked_s) begin
                    state_n = S_STABLE;
                end else if (cnt == TIMEOUT_LAST) begin
                    state_n     = S_RESET_PLL;
                    timeout_evt = 1'b1;
                end
            end
            S_STABLE: begin
                if (!locked_s)                state_n = S_WAIT_LOCK;
                else if (cnt == STABLE_LAST)  state_n = S_RUN;
            end
            S_RUN: begin
                if (!locked_s) begin
                    state_n      = S_RESET_PLL;
                    lockloss_evt = 1'b1;
                end
            end
            default: state_n = S_RESET_PLL;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state            <= S_RESET_PLL;
            cnt              <= '0;
            sync1            <= 1'b0;
            locked_s         <= 1'b0;
            pll_rst_o        <= 1'b1;
            rst_o            <= 1'b1;
            ready_o          <= 1'b0;
            lock_lost_o      <= 1'b0;
            timeout_count_o  <= '0;
            lockloss_count_o <= '0;
        end else begin
            sync1    <= pll_locked_i;
            locked_s <= sync1;
            state    <= state_n;

            // RUN has no timed exit, so the counter is parked there.
            if (state_n != state)    cnt <= '0;
            else if (state != S_RUN) cnt <= cnt + 24'd1;

            pll_rst_o   <= (state_n == S_RESET_PLL);
            rst_o       <= (state_n != S_RUN);
            ready_o     <= (state_n == S_RUN);
            lock_lost_o <= lockloss_evt;

            if (timeout_evt && (timeout_count_o != 8'hFF))
                timeout_count_o <= timeout_count_o + 8'd1;
            if (lockloss_evt && (lockloss_count_o != 8'hFF))
                lockloss_count_o <= lockloss_count_o + 8'd1;
        end
    end

endmodule

// File: tb/tb_pll_reset_seq.sv
// Bench for pll_reset_seq: directed scenarios with literal expectations plus
// random lock/reset stimulus, all compared every cycle against a phase model.
module tb_pll_reset_seq;

    localparam int PRC = 4;
    localparam int LTO = 32;
    localparam int STC = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       pll_locked = 1'b0;
    logic       pll_rst;
    logic       sys_rst;
    logic       ready;
    logic       lock_lost;
    logic [7:0] timeout_count;
    logic [7:0] lockloss_count;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    pll_reset_seq #(
        .PLL_RST_CYCLES(PRC),
        .LOCK_TIMEOUT  (LTO),
        .STABLE_CYCLES (STC)
    ) dut (
        .clk_i           (clk),
        .rst_n_i         (rst_n),
        .pll_locked_i    (pll_locked),
        .pll_rst_o       (pll_rst),
        .rst_o           (sys_rst),
        .ready_o         (ready),
        .lock_lost_o     (lock_lost),
        .timeout_count_o (timeout_count),
        .lockloss_count_o(lockloss_count)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- phase model ----------------
    typedef enum int {PH_PLLRST, PH_WAIT, PH_QUAL, PH_RUN} phase_t;
    phase_t m_phase = PH_PLLRST;
    int     m_age   = 0;     // cycles already spent in the current phase
    int     m_to    = 0;
    int     m_ll    = 0;
    bit     m_lost  = 0;
    bit     m_valid = 0;
    bit     seen_q[$];       // raw lock samples; the sequencer acts on the one two edges old

    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            m_valid = 1;
            m_phase = PH_PLLRST;
            m_age   = 0;
            m_to    = 0;
            m_ll    = 0;
            m_lost  = 0;
            seen_q  = '{0, 0};
        end else if (m_valid) begin
            bit     ls;
            phase_t nxt;
            ls = seen_q.pop_front();
            seen_q.push_back(pll_locked);
            nxt    = m_phase;
            m_lost = 0;
            case (m_phase)
                PH_PLLRST: if (m_age + 1 >= PRC) nxt = PH_WAIT;
                PH_WAIT: begin
                    if (ls) nxt = PH_QUAL;
                    else if (m_age + 1 >= LTO) begin
                        nxt  = PH_PLLRST;
                        m_to = (m_to < 255) ? m_to + 1 : 255;
                    end
                end
                PH_QUAL: begin
                    if (!ls) nxt = PH_WAIT;
                    else if (m_age + 1 >= STC) nxt = PH_RUN;
                end
                default: begin
                    if (!ls) begin
                        nxt    = PH_PLLRST;
                        m_lost = 1;
                        m_ll   = (m_ll < 255) ? m_ll + 1 : 255;
                    end
                end
            endcase
            m_age   = (nxt == m_phase) ? m_age + 1 : 0;
            m_phase = nxt;
        end
        if (m_valid) begin
            chk("m_pll_rst", int'(pll_rst), int'(m_phase == PH_PLLRST));
            chk("m_rst", int'(sys_rst), int'(m_phase != PH_RUN));
            chk("m_ready", int'(ready), int'(m_phase == PH_RUN));
            chk("m_lock_lost", int'(lock_lost), int'(m_lost));
            chk("m_timeout_count", int'(timeout_count), m_to);
            chk("m_lockloss_count", int'(lockloss_count), m_ll);
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic r, input logic l);
        @(negedge clk);
        rst_n      = r;
        pll_locked = l;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_pll_rst"}, int'(pll_rst), 1);
        chk({tag, "_rst"}, int'(sys_rst), 1);
        chk({tag, "_ready"}, int'(ready), 0);
        chk({tag, "_lock_lost"}, int'(lock_lost), 0);
        chk({tag, "_timeout_count"}, int'(timeout_count), 0);
        chk({tag, "_lockloss_count"}, int'(lockloss_count), 0);
    endtask

    // Counts pll_rst high cycles from the last reset edge over the next 10 edges.
    task automatic count_pll_rst(input string tag);
        int c;
        c = int'(pll_rst);
        drive(1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick();
            c += int'(pll_rst);
        end
        chk({tag, "_pll_rst_len"}, c, 4);
    endtask

    // Edge index (first edge after the lock rise = 0) at which rst_o falls.
    task automatic rst_fall_index(input string tag);
        int k;
        k = 0;
        do begin
            tick();
            k++;
        end while (sys_rst && k < 60);
        chk({tag, "_rst_fall_edge"}, k - 1, 10);
    endtask

    initial begin
        int mism;
        int hold;
        logic lv;

        // Reset then lock
        drive(1'b0, 1'b0);
        repeat (3) tick();
        check_reset_values("rst");
        count_pll_rst("s1");
        drive(1'b1, 1'b1);
        rst_fall_index("s1");
        chk("s1_ready", int'(ready), 1);
        chk("s1_timeout_count", int'(timeout_count), 0);
        chk("s1_lockloss_count", int'(lockloss_count), 0);

        // Lock loss in RUN, then relock
        drive(1'b1, 1'b0);
        repeat (3) tick();
        chk("loss_rst", int'(sys_rst), 1);
        chk("loss_pll_rst", int'(pll_rst), 1);
        chk("loss_ready", int'(ready), 0);
        chk("loss_pulse", int'(lock_lost), 1);
        tick();
        chk("loss_pulse_end", int'(lock_lost), 0);
        chk("loss_count", int'(lockloss_count), 1);
        drive(1'b1, 1'b1);
        for (int i = 0; i < 60 && !ready; i++) tick();
        chk("relock_ready", int'(ready), 1);

        // Unstable lock during qualification
        drive(1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b0);
        repeat (5) tick();
        drive(1'b1, 1'b1);
        repeat (6) tick();
        drive(1'b1, 1'b0);
        tick();
        drive(1'b1, 1'b1);
        rst_fall_index("glitch");
        chk("glitch_timeout_count", int'(timeout_count), 0);

        // Reset mid-qualification
        drive(1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b0);
        repeat (5) tick();
        drive(1'b1, 1'b1);
        repeat (5) tick();
        drive(1'b0, 1'b0);
        tick();
        check_reset_values("midrst");
        count_pll_rst("midrst");

        // No lock: periodic PLL reset, then saturation
        drive(1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b0);
        mism = 0;
        for (int k = 1; k <= 200; k++) begin
            tick();
            if (pll_rst != ((k % 36) < 4)) mism++;
            if (!sys_rst) mism++;
            if (k == 180) chk("nolock_timeout_180", int'(timeout_count), 5);
        end
        chk("nolock_pattern_errors", mism, 0);
        repeat (300 * 36) tick();
        chk("sat_timeout_count", int'(timeout_count), 255);

        // Random lock behaviour with occasional resets
        drive(1'b0, 1'b0);
        tick();
        lv   = 1'b0;
        hold = 0;
        for (int i = 0; i < 4000; i++) begin
            if (hold == 0) begin
                lv   = ~lv;
                hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3)
                                                   : $urandom_range(5, 60);
            end
            hold--;
            drive(($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1, lv);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
